// File: rtl/hdmi_pkg.sv
// Shared types and timing constants for the HDMI period scheduler.
package hdmi_pkg;

   // Period type presented to the TMDS encoder for each pixel.
   typedef enum logic [2:0] {
      ModeCtrl   = 3'd0,
      ModeVidPre = 3'd1,
      ModeVidGb  = 3'd2,
      ModeVideo  = 3'd3,
      ModeDiPre  = 3'd4,
      ModeDiLgb  = 3'd5,
      ModeData   = 3'd6,
      ModeDiTgb  = 3'd7
   } mode_t;

   // Data-island sequencer states.
   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StLgb,
      StPkt,
      StTgb,
      StGap
   } island_st_e;

   localparam int unsigned PreambleLen = 8;
   localparam int unsigned GuardLen    = 2;
   localparam int unsigned PacketLen   = 32;
   localparam int unsigned IslandGap   = 4;
   localparam int unsigned VideoLead   = 10;

   // Shortest possible island: preamble, both guards and one packet.
   localparam int unsigned IslandLen = PreambleLen + 2 * GuardLen + PacketLen;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, pointer moves past
// the winner whenever the advance strobe is asserted.
module rr_arbiter #(
   parameter int unsigned NumReq = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NumReq-1:0] req_i,
   input  logic              advance_i,
   output logic [NumReq-1:0] gnt_o
);

   localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] idx;
   logic            found;

   // Search from the pointer upwards, wrapping, for the first active request.
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(NumReq); i++) begin
         idx = PtrW'((int'(ptr_q) + i) % int'(NumReq));
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            if (advance_i) begin
               ptr_d = PtrW'((int'(idx) + 1) % int'(NumReq));
            end
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer with data-island packet scheduling.
// Outputs are registered: they describe the cx/cy sampled one cycle earlier.
// Build option DI_ISLAND_EN enables preambles, guard bands and data islands;
// without it the block behaves as a plain DVI CTRL/VIDEO sequencer.
module hdmi_period_scheduler
   import hdmi_pkg::*;
#(
   parameter int unsigned ScreenWidth  = 640,
   parameter int unsigned ScreenHeight = 480,
   parameter int unsigned FrameWidth   = 800,
   parameter int unsigned FrameHeight  = 525,
   parameter int unsigned NumReq       = 4,
   parameter int unsigned MaxPackets   = 18
) (
   input  logic                           clk_pixel_i,
   input  logic                           reset_i,
   input  logic [$clog2(FrameWidth)-1:0]  cx_i,
   input  logic [$clog2(FrameHeight)-1:0] cy_i,
   input  logic [NumReq-1:0]              packet_req_i,
   output mode_t                          mode_o,
   output logic [NumReq-1:0]              packet_grant_o,
   output logic [4:0]                     packet_cycle_o,
   output logic                           packet_ack_o
);

   int    cx_int, cy_int;
   mode_t vid_mode;
   mode_t mode_d, mode_q;

   assign cx_int = int'(cx_i);
   assign cy_int = int'(cy_i);

`ifdef DI_ISLAND_EN
   // Island window shared by every line; keeps clear of active video and the
   // video preamble of the following line.
   localparam int WLo = int'(ScreenWidth) + 4;
   localparam int WHi = int'(FrameWidth) - 14;

   localparam logic [4:0] PreLast = 5'(PreambleLen - 1);
   localparam logic [4:0] GbLast  = 5'(GuardLen - 1);
   localparam logic [4:0] PktLast = 5'(PacketLen - 1);
   localparam logic [4:0] GapLast = 5'(IslandGap - 1);
   localparam int unsigned PktCntW = $clog2(MaxPackets + 1);

   int ny_int;

   // Video period of this pixel, including the lead-in before an active line.
   always_comb begin
      ny_int   = (cy_int + 1 == int'(FrameHeight)) ? 0 : cy_int + 1;
      vid_mode = ModeCtrl;
      if (cx_int < int'(ScreenWidth) && cy_int < int'(ScreenHeight)) begin
         vid_mode = ModeVideo;
      end else if (ny_int < int'(ScreenHeight)) begin
         if (cx_int >= int'(FrameWidth - VideoLead) &&
             cx_int <= int'(FrameWidth - GuardLen) - 1) begin
            vid_mode = ModeVidPre;
         end else if (cx_int >= int'(FrameWidth - GuardLen)) begin
            vid_mode = ModeVidGb;
         end
      end
   end

   island_st_e          st_q, st_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [PktCntW-1:0]  npkt_q, npkt_d;
   logic [NumReq-1:0]   grant_q, grant_d;
   logic [NumReq-1:0]   arb_req, arb_gnt;
   logic                advance;
   logic [4:0]          pcycle_d, pcycle_q;
   logic                ack_d, ack_q;

   // The source being acked is never re-picked for the back-to-back slot.
   assign arb_req = packet_req_i & ~grant_q;

   rr_arbiter #(
      .NumReq(NumReq)
   ) u_arb (
      .clk_i    (clk_pixel_i),
      .reset_i  (reset_i),
      .req_i    (arb_req),
      .advance_i(advance),
      .gnt_o    (arb_gnt)
   );

   // Island sequencing; st_d is the state of the pixel being sampled now.
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      npkt_d  = npkt_q;
      grant_d = grant_q;
      advance = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (|packet_req_i && cx_int >= WLo && cx_int + int'(IslandLen) <= WHi) begin
               st_d  = StPre;
               cnt_d = '0;
            end
         end
         StPre: begin
            if (cnt_q == PreLast) begin
               st_d  = StLgb;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         StLgb: begin
            if (cnt_q == GbLast) begin
               cnt_d = '0;
               if (|arb_gnt) begin
                  st_d    = StPkt;
                  grant_d = arb_gnt;
                  advance = 1'b1;
                  npkt_d  = PktCntW'(1);
               end else begin
                  // Request withdrawn during the preamble: close the island empty.
                  st_d = StTgb;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         StPkt: begin
            if (cnt_q == PktLast) begin
               cnt_d = '0;
               if (|arb_gnt && npkt_q < PktCntW'(MaxPackets) &&
                   cx_int + int'(PacketLen) + int'(GuardLen) <= WHi) begin
                  grant_d = arb_gnt;
                  advance = 1'b1;
                  npkt_d  = npkt_q + PktCntW'(1);
               end else begin
                  st_d    = StTgb;
                  grant_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         StTgb: begin
            if (cnt_q == GbLast) begin
               st_d  = StGap;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               st_d  = StIdle;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: begin
            st_d  = StIdle;
            cnt_d = '0;
         end
      endcase
      // Video always wins; an island colliding with it is dropped outright.
      if (vid_mode != ModeCtrl && st_d != StIdle && st_d != StGap) begin
         st_d    = StIdle;
         cnt_d   = '0;
         npkt_d  = '0;
         grant_d = '0;
         advance = 1'b0;
      end
   end

   // Period type, packet index and ack for the pixel being sampled.
   always_comb begin
      mode_d   = vid_mode;
      pcycle_d = '0;
      ack_d    = 1'b0;
      unique case (st_d)
         StPre: mode_d = ModeDiPre;
         StLgb: mode_d = ModeDiLgb;
         StPkt: begin
            mode_d   = ModeData;
            pcycle_d = cnt_d;
            ack_d    = (cnt_d == PktLast);
         end
         StTgb:   mode_d = ModeDiTgb;
         default: ;
      endcase
   end

   // Island state and packet outputs.
   always_ff @(posedge clk_pixel_i) begin
      if (reset_i) begin
         st_q     <= StIdle;
         cnt_q    <= '0;
         npkt_q   <= '0;
         grant_q  <= '0;
         pcycle_q <= '0;
         ack_q    <= 1'b0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         npkt_q   <= npkt_d;
         grant_q  <= grant_d;
         pcycle_q <= pcycle_d;
         ack_q    <= ack_d;
      end
   end

   assign packet_grant_o = grant_q;
   assign packet_cycle_o = pcycle_q;
   assign packet_ack_o   = ack_q;
`else
   logic unused_req;
   assign unused_req = ^packet_req_i;

   // DVI: only active video or control.
   always_comb begin
      vid_mode = ModeCtrl;
      if (cx_int < int'(ScreenWidth) && cy_int < int'(ScreenHeight)) begin
         vid_mode = ModeVideo;
      end
   end

   assign mode_d         = vid_mode;
   assign packet_grant_o = '0;
   assign packet_cycle_o = '0;
   assign packet_ack_o   = 1'b0;
`endif

   // Registered period type.
   always_ff @(posedge clk_pixel_i) begin
      if (reset_i) begin
         mode_q <= ModeCtrl;
      end else begin
         mode_q <= mode_d;
      end
   end

   assign mode_o = mode_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler: the stimulus pushes the expected
// output of each driven pixel, a negedge monitor pops and compares.
module tb_hdmi_period_scheduler;
   import hdmi_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] cx, cy;
   logic       rst_a, rst_b;
   logic [3:0] req_a, req_b;
   mode_t      mode_a, mode_b;
   logic [3:0] gnt_a, gnt_b;
   logic [4:0] pc_a, pc_b;
   logic       ack_a, ack_b;

   hdmi_period_scheduler #(
      .ScreenWidth (640),
      .ScreenHeight(480),
      .FrameWidth  (800),
      .FrameHeight (525),
      .NumReq      (4),
      .MaxPackets  (18)
   ) u_dut (
      .clk_pixel_i   (clk),
      .reset_i       (rst_a),
      .cx_i          (cx),
      .cy_i          (cy),
      .packet_req_i  (req_a),
      .mode_o        (mode_a),
      .packet_grant_o(gnt_a),
      .packet_cycle_o(pc_a),
      .packet_ack_o  (ack_a)
   );

   hdmi_period_scheduler #(
      .ScreenWidth (640),
      .ScreenHeight(480),
      .FrameWidth  (800),
      .FrameHeight (525),
      .NumReq      (4),
      .MaxPackets  (2)
   ) u_dut_cap (
      .clk_pixel_i   (clk),
      .reset_i       (rst_b),
      .cx_i          (cx),
      .cy_i          (cy),
      .packet_req_i  (req_b),
      .mode_o        (mode_b),
      .packet_grant_o(gnt_b),
      .packet_cycle_o(pc_b),
      .packet_ack_o  (ack_b)
   );

   typedef struct {
      int unsigned when;
      bit          which;
      mode_t       mode;
      logic [3:0]  gnt;
      logic [4:0]  pc;
      logic        ack;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   // Expected island layout for the current run (start < 0 disables).
   int         isl1_s, isl1_np, isl2_s;
   logic [3:0] isl1_g0, isl1_g1, isl2_g;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every queued expectation due at this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].when <= cyc) begin
         mode_t      am;
         logic [3:0] ag;
         logic [4:0] ap;
         logic       aa;
         mon_e = sb.pop_front();
         n_tests++;
         if (mon_e.which) begin
            am = mode_b; ag = gnt_b; ap = pc_b; aa = ack_b;
         end else begin
            am = mode_a; ag = gnt_a; ap = pc_a; aa = ack_a;
         end
         if (mon_e.when != cyc) begin
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d checked late at %0d", mon_e.name,
                     mon_e.when, cyc);
         end else if (am !== mon_e.mode || ag !== mon_e.gnt || ap !== mon_e.pc ||
                      aa !== mon_e.ack) begin
            n_fail++;
            $display("FAIL %s: got mode=%0d grant=%b cycle=%0d ack=%b, want mode=%0d grant=%b cycle=%0d ack=%b",
                     mon_e.name, am, ag, ap, aa, mon_e.mode, mon_e.gnt, mon_e.pc, mon_e.ack);
         end
      end
   end

   task automatic push(input bit w, input mode_t m, input logic [3:0] g, input logic [4:0] pc,
                       input logic a, input string nm);
      exp_t e;
      e.when  = cyc + 1;
      e.which = w;
      e.mode  = m;
      e.gnt   = g;
      e.pc    = pc;
      e.ack   = a;
      e.name  = nm;
      sb.push_back(e);
   endtask

   task automatic pix(input int x, input int y);
      cx = 10'(x);
      cy = 10'(y);
      @(posedge clk);
      #1;
   endtask

   // 640x480 in 800x525, islands as written in the test plan.
   function automatic mode_t video_at(input int x, input int y);
      int ny;
      ny = (y == 524) ? 0 : y + 1;
      if (x < 640 && y < 480) return ModeVideo;
`ifdef DI_ISLAND_EN
      if (ny < 480 && x >= 790 && x <= 797) return ModeVidPre;
      if (ny < 480 && x >= 798) return ModeVidGb;
`endif
      return ModeCtrl;
   endfunction

   function automatic bit island_at(input int x, input int s, input int np, input logic [3:0] g0,
                                    input logic [3:0] g1, output mode_t m,
                                    output logic [3:0] g, output logic [4:0] pc,
                                    output logic a);
      int d;
      d  = x - s;
      m  = ModeCtrl;
      g  = '0;
      pc = '0;
      a  = 1'b0;
      if (s < 0 || d < 0) return 1'b0;
      if (d < 8) begin m = ModeDiPre; return 1'b1; end
      if (d < 10) begin m = ModeDiLgb; return 1'b1; end
      if (d < 10 + 32 * np) begin
         m  = ModeData;
         g  = ((d - 10) < 32) ? g0 : g1;
         pc = 5'((d - 10) % 32);
         a  = (((d - 10) % 32) == 31);
         return 1'b1;
      end
      if (d < 12 + 32 * np) begin m = ModeDiTgb; return 1'b1; end
      return 1'b0;
   endfunction

   // Drive a run of pixels on one line; requesters drop the acked bit next cycle.
   task automatic run(input bit w, input int y, input int x0, input int x1, input int raise_x,
                      input logic [3:0] raise_v, input string tag);
      for (int x = x0; x <= x1; x++) begin
         mode_t      m;
         logic [3:0] g;
         logic [4:0] pc;
         logic       a;
         if (x == raise_x) begin
            if (w) req_b = req_b | raise_v;
            else   req_a = req_a | raise_v;
         end
         if (!island_at(x, isl1_s, isl1_np, isl1_g0, isl1_g1, m, g, pc, a)) begin
            if (!island_at(x, isl2_s, 1, isl2_g, 4'b0000, m, g, pc, a)) begin
               m = video_at(x, y);
            end
         end
         push(w, m, g, pc, a, $sformatf("%s y=%0d x=%0d", tag, y, x));
         pix(x, y);
         if (w) begin
            if (ack_b) req_b = req_b & ~gnt_b;
         end else begin
            if (ack_a) req_a = req_a & ~gnt_a;
         end
      end
   endtask

   task automatic set_isl(input int s1, input int np, input logic [3:0] g0, input logic [3:0] g1,
                          input int s2, input logic [3:0] g2);
      isl1_s  = s1;
      isl1_np = np;
      isl1_g0 = g0;
      isl1_g1 = g1;
      isl2_s  = s2;
      isl2_g  = g2;
   endtask

   task automatic rst_pulse(input bit w);
      if (w) begin rst_b = 1'b1; req_b = '0; end
      else begin rst_a = 1'b1; req_a = '0; end
      pix(700, 5);
      rst_a = 1'b0;
      rst_b = 1'b0;
   endtask

   initial begin
      cx = '0; cy = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      req_a = '0; req_b = '0;
      set_isl(-1, 1, 4'b0000, 4'b0000, -1, 4'b0000);
      @(posedge clk);
      #1;
      // Reset state, then the first pixel after reset.
      push(1'b0, ModeCtrl, 4'b0000, 5'd0, 1'b0, "reset a");
      push(1'b1, ModeCtrl, 4'b0000, 5'd0, 1'b0, "reset b");
      pix(100, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      push(1'b0, ModeVideo, 4'b0000, 5'd0, 1'b0, "post-reset a");
      push(1'b1, ModeVideo, 4'b0000, 5'd0, 1'b0, "post-reset b");
      pix(100, 0);

`ifdef DI_ISLAND_EN
      // Video edges around the first active line and the frame wrap.
      run(1'b0, 9, 780, 799, -1, 4'b0000, "vid edge");
      run(1'b0, 10, 0, 643, -1, 4'b0000, "vid line");
      run(1'b0, 479, 788, 799, -1, 4'b0000, "last line");
      run(1'b0, 524, 788, 799, -1, 4'b0000, "frame wrap");

      // Single request from source 1.
      rst_pulse(1'b0);
      set_isl(644, 1, 4'b0010, 4'b0000, -1, 4'b0000);
      run(1'b0, 10, 600, 700, 600, 4'b0010, "single");

      // Two requesters packed into one island.
      rst_pulse(1'b0);
      set_isl(644, 2, 4'b0001, 4'b0100, -1, 4'b0000);
      run(1'b0, 20, 600, 730, 600, 4'b0101, "arb");

      // Packet cap of 2 splits three requests into two islands.
      rst_pulse(1'b1);
      set_isl(644, 2, 4'b0001, 4'b0010, 724, 4'b0100);
      run(1'b1, 30, 600, 775, 600, 4'b0111, "cap");

      // Late request waits for the next line's window.
      set_isl(-1, 1, 4'b0000, 4'b0000, -1, 4'b0000);
      run(1'b0, 40, 740, 799, 743, 4'b1000, "late");
      set_isl(644, 1, 4'b1000, 4'b0000, -1, 4'b0000);
      run(1'b0, 41, 0, 700, -1, 4'b0000, "late next");

      // Reset in the middle of a packet.
      rst_pulse(1'b0);
      set_isl(644, 1, 4'b0010, 4'b0000, -1, 4'b0000);
      run(1'b0, 50, 600, 664, 600, 4'b0010, "pre-reset");
      rst_a = 1'b1;
      push(1'b0, ModeCtrl, 4'b0000, 5'd0, 1'b0, "reset in data");
      pix(665, 50);
      rst_a = 1'b0;
      run(1'b0, 51, 600, 700, -1, 4'b0000, "after reset");
`else
      // DVI: requests held everywhere, only CTRL/VIDEO and no packet activity.
      run(1'b0, 9, 780, 799, 780, 4'b1111, "dvi edge");
      run(1'b0, 10, 0, 799, -1, 4'b0000, "dvi line");
      run(1'b0, 479, 630, 645, -1, 4'b0000, "dvi last");
      run(1'b0, 524, 780, 799, -1, 4'b0000, "dvi wrap");
      run(1'b1, 30, 600, 799, 600, 4'b1111, "dvi cap");
`endif

      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: never checked, want mode=%0d", e.name, e.mode);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Per-pixel period sequencer for the HDMI transmit path, clocked by `clk_pixel` one stage ahead of TMDS encoding and the serializer. It turns raster position into the HDMI period type (control, preambles, guard bands, video, data island) for each pixel. It also schedules data-island packets by arbitrating round-robin among packet sources, packing back-to-back packets into islands that fit inside horizontal blanking.

## Interface
- `SCREEN_WIDTH`, 640: active pixels per line.
- `SCREEN_HEIGHT`, 480: active lines.
- `FRAME_WIDTH`, 800: total pixels per line.
- `FRAME_HEIGHT`, 525: total lines.
- `NUM_REQ`, 4: number of packet requesters.
- `MAX_PACKETS`, 18: packet cap per island.
- `clk_pixel` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `cx` in $clog2(FRAME_WIDTH): current pixel column.
- `cy` in $clog2(FRAME_HEIGHT): current line.
- `packet_req` in NUM_REQ: level request per source, held until acked.
- `mode` out 3: period type (`hdmi_pkg::mode_t`).
- `packet_grant` out NUM_REQ: one-hot owner of the current packet slot; zero otherwise.
- `packet_cycle` out 5: 0..31 index within the packet; 0 outside DATA.
- `packet_ack` out 1: pulse on the last DATA cycle of a packet (`packet_cycle` == 31).

## Operation
- Mode encoding:
  - CTRL=0, VID_PRE=1, VID_GB=2, VIDEO=3.
  - DI_PRE=4, DI_LGB=5, DATA=6, DI_TGB=7.
- VIDEO: `cx` < SCREEN_WIDTH and `cy` < SCREEN_HEIGHT.
- Next line: `cy`+1, wrapping to 0 at FRAME_HEIGHT.
- If the next line is active:
  - VID_PRE for `cx` in [FRAME_WIDTH-10, FRAME_WIDTH-3].
  - VID_GB for `cx` in [FRAME_WIDTH-2, FRAME_WIDTH-1].
- Island window, evaluated identically on every line including vertical blanking: W_LO = SCREEN_WIDTH+4, W_HI = FRAME_WIDTH-14.
- Island FSM states: IDLE → PRE (8 cycles) → LGB (2) → PKT (32 per packet) → TGB (2) → GAP (4 cycles CTRL) → IDLE.
- IDLE → PRE when all of the following hold:
  - any `packet_req` is set and DI_ISLAND_EN is defined;
  - `cx` ≥ W_LO;
  - `cx`+44 ≤ W_HI.
- Entering PKT, and at each packet boundary, the round-robin arbiter picks one requester:
  - the pointer advances to just past the winner;
  - `packet_grant` holds stable for 32 cycles.
- At `packet_cycle` 31, continue with another packet only if all hold; otherwise go to TGB:
  - any `packet_req` is set, excluding the source being acked this cycle;
  - fewer than MAX_PACKETS packets are done;
  - `cx`+1+32+2 ≤ W_HI.
- Island windows never overlap the video preamble, so video periods take precedence only as a defensive check.
- If a violation is detected, the FSM aborts to IDLE with grant 0 and no ack. This is unreachable with legal parameters and is an assertion target.
- Requests arriving during video or after the window closes wait for the next line's window.
- Reset:
  - `mode`=CTRL, `packet_grant`=0, `packet_cycle`=0, `packet_ack`=0;
  - FSM=IDLE, arbiter pointer=0;
  - held requests are served after reset.

## Timing
- All outputs are registered; the output at cycle t+1 reflects `cx`/`cy` sampled at t (latency 1).
- Downstream delays its pixel data by 1 cycle to stay aligned.
- `packet_ack` is coincident with the last `packet_grant` cycle. The requester may drop `packet_req` the following cycle.
- A request deasserted without an ack is legal. It affects only future arbitration, never a granted slot.

## Configuration
- `DI_ISLAND_EN` defined:
  - full behaviour as above.
- `DI_ISLAND_EN` undefined (DVI):
  - `mode` is only CTRL or VIDEO, with no preambles or guards;
  - `packet_grant`, `packet_cycle` and `packet_ack` are tied 0;
  - requests are ignored;
  - FSM and arbiter are not instantiated.

## Structure
- `hdmi_pkg`:
  - `mode_t` enum;
  - constants PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, ISLAND_GAP=4, VIDEO_LEAD=10.
- Sub-module `rr_arbiter`, parameterized by NUM_REQ:
  - inputs: req, advance strobe;
  - output: one-hot grant;
  - pointer is reset by `reset`.

## Test plan
- Single request, 640x480/800x525, `packet_req[1]` raised at line 10 `cx`=600. Output `cx` indices:
  - DI_PRE at 644–651, DI_LGB at 652–653;
  - DATA with grant=0010 at 654–685, ack at 685;
  - DI_TGB at 686–687, then CTRL.
- Video edges:
  - line 9: VID_PRE at `cx` 790–797, VID_GB at 798–799, then VIDEO at line 10 `cx` 0–639;
  - line 479 `cx` 790: CTRL, since line 480 is inactive;
  - line 524 `cx` 790: VID_PRE.
- Arbitration: `req[0]` and `req[2]` set at `cx`=600:
  - one island with two packets, grants 0001 then 0100;
  - DATA at 654–717, DI_TGB at 718–719.
- MAX_PACKETS=2 with `req[0..2]` held:
  - first island ends with TGB at 718–719;
  - CTRL at 720–723;
  - second island DI_PRE at 724 serves `req[2]`.
- Late request: `req[3]` at `cx`=743 → no island on this line; DI_PRE at `cx` 644 next line.
- Reset at DATA `packet_cycle` 10:
  - next cycle: CTRL, grant 0, no ack;
  - the still-held request is served at the next window.
- DVI build: `req` held a full frame → `mode` only toggles CTRL/VIDEO; grant, cycle and ack stay 0.
